// File: rtl/vend_arbiter_ctrl.sv
// rtl/vend_arbiter_ctrl.sv - two-slot coin arbiter and vend controller with round-robin first-coin grant.
// Optional sales_cnt output when VEND_ARBITER_CTRL_AUDIT_EN is defined.
module vend_arbiter_ctrl #(
  parameter int PRICE   = 3,
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] coin_a,
  input  logic [1:0] coin_b,
  input  logic       motor_ack,
  output logic [1:0] owner,
  output logic       reject_a,
  output logic       reject_b,
  output logic [2:0] credit,
  output logic       motor_req,
  output logic [1:0] change,
  output logic       change_vld,
  output logic [2:0] refund,
  output logic       refund_vld,
  output logic       busy
`ifdef VEND_ARBITER_CTRL_AUDIT_EN
  ,
  output logic [7:0] sales_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_VEND,
    S_CHANGE,
    S_REFUND
  } state_t;

  localparam logic [2:0] LP_PRICE   = 3'(PRICE);
  localparam logic [7:0] LP_TO_LAST = 8'(TIMEOUT - 1);

  state_t     r_state;
  state_t     w_next;
  logic [1:0] r_owner;
  logic [2:0] r_credit;
  logic [7:0] r_idle_cnt;
  logic       r_rr_b;
  logic       r_rej_a;
  logic       r_rej_b;

  logic       w_ok_a;
  logic       w_ok_b;
  logic       w_acc_a;
  logic       w_acc_b;
  logic       w_coin;
  logic [2:0] w_val_a;
  logic [2:0] w_val_b;
  logic [2:0] w_sum;
  logic       w_hit;
  logic [1:0] w_change;

  assign w_ok_a  = (coin_a == 2'd1) || (coin_a == 2'd2);
  assign w_ok_b  = (coin_b == 2'd1) || (coin_b == 2'd2);
  assign w_val_a = w_ok_a ? {1'b0, coin_a} : 3'd0;
  assign w_val_b = w_ok_b ? {1'b0, coin_b} : 3'd0;

  // Only one coin is ever accepted per cycle: in IDLE the round-robin pointer
  // breaks ties, in COLLECT only the session owner's slot is open.
  always_comb begin
    w_acc_a = 1'b0;
    w_acc_b = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_acc_a = w_ok_a && (!w_ok_b || !r_rr_b);
        w_acc_b = w_ok_b && (!w_ok_a || r_rr_b);
      end
      S_COLLECT: begin
        w_acc_a = w_ok_a && (r_owner == 2'b01);
        w_acc_b = w_ok_b && (r_owner == 2'b10);
      end
      default: ;
    endcase
  end

  assign w_coin   = w_acc_a || w_acc_b;
  assign w_sum    = r_credit + (w_acc_a ? w_val_a : (w_acc_b ? w_val_b : 3'd0));
  assign w_hit    = w_sum >= LP_PRICE;
  assign w_change = r_credit[1:0] - LP_PRICE[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_coin) w_next = w_hit ? S_VEND : S_COLLECT;
      end
      S_COLLECT: begin
        // An accepted coin on the expiry cycle takes priority over the refund.
        if (w_coin) begin
          if (w_hit) w_next = S_VEND;
        end else if (r_idle_cnt == LP_TO_LAST) begin
          w_next = S_REFUND;
        end
      end
      S_VEND: begin
        if (motor_ack) w_next = S_CHANGE;
      end
      S_CHANGE: w_next = S_IDLE;
      S_REFUND: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner    <= 2'b00;
      r_credit   <= 3'd0;
      r_idle_cnt <= 8'd0;
      r_rr_b     <= 1'b0;
      r_rej_a    <= 1'b0;
      r_rej_b    <= 1'b0;
    end else begin
      r_rej_a <= (coin_a != 2'd0) && !w_acc_a;
      r_rej_b <= (coin_b != 2'd0) && !w_acc_b;
      case (r_state)
        S_IDLE: begin
          if (w_coin) begin
            r_owner    <= w_acc_a ? 2'b01 : 2'b10;
            r_credit   <= w_sum;
            r_rr_b     <= w_acc_a;
            r_idle_cnt <= 8'd0;
          end
        end
        S_COLLECT: begin
          if (w_coin) begin
            r_credit   <= w_sum;
            r_idle_cnt <= 8'd0;
          end else begin
            r_idle_cnt <= r_idle_cnt + 8'd1;
          end
        end
        S_CHANGE, S_REFUND: begin
          r_credit <= 3'd0;
          r_owner  <= 2'b00;
        end
        default: ;
      endcase
    end
  end

`ifdef VEND_ARBITER_CTRL_AUDIT_EN
  logic [7:0] r_sales_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                    r_sales_cnt <= 8'd0;
    else if ((r_state == S_VEND) && motor_ack) r_sales_cnt <= r_sales_cnt + 8'd1;
  end

  assign sales_cnt = r_sales_cnt;
`endif

  always_comb begin
    owner      = r_owner;
    credit     = r_credit;
    reject_a   = r_rej_a;
    reject_b   = r_rej_b;
    busy       = (r_state != S_IDLE);
    motor_req  = (r_state == S_VEND);
    change_vld = (r_state == S_CHANGE);
    change     = (r_state == S_CHANGE) ? w_change : 2'd0;
    refund_vld = (r_state == S_REFUND);
    refund     = (r_state == S_REFUND) ? r_credit : 3'd0;
  end

endmodule

// File: tb/tb_vend_arbiter_ctrl.sv
// tb/tb_vend_arbiter_ctrl.sv - randomized and directed bench with a session-level reference model.
// Also checks sales_cnt when VEND_ARBITER_CTRL_AUDIT_EN is defined.
module tb_vend_arbiter_ctrl;

  localparam int PRICE   = 3;
  localparam int TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] coin_a;
  logic [1:0] coin_b;
  logic       motor_ack;
  logic [1:0] owner;
  logic       reject_a;
  logic       reject_b;
  logic [2:0] credit;
  logic       motor_req;
  logic [1:0] change;
  logic       change_vld;
  logic [2:0] refund;
  logic       refund_vld;
  logic       busy;
`ifdef VEND_ARBITER_CTRL_AUDIT_EN
  logic [7:0] sales_cnt;
`endif

  vend_arbiter_ctrl #(.PRICE(PRICE), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .coin_a(coin_a), .coin_b(coin_b), .motor_ack(motor_ack),
    .owner(owner), .reject_a(reject_a), .reject_b(reject_b), .credit(credit),
    .motor_req(motor_req), .change(change), .change_vld(change_vld),
    .refund(refund), .refund_vld(refund_vld), .busy(busy)
`ifdef VEND_ARBITER_CTRL_AUDIT_EN
    , .sales_cnt(sales_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Session-level reference: phase 0 waiting, 1 paying, 2 dispensing, 3 change, 4 refund.
  int m_phase, m_owner, m_credit, m_quiet, m_next_slot, m_sales;
  bit m_rej_a, m_rej_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int coin_value(input int code);
    return (code == 1) ? 1 : (code == 2) ? 2 : 0;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_owner = 0; m_credit = 0; m_quiet = 0;
    m_next_slot = 1; m_sales = 0; m_rej_a = 0; m_rej_b = 0;
  endtask

  task automatic model_step(input int ca, input int cb, input int ack);
    int code[2];
    bit took[2];
    int winner;
    code[0] = ca; code[1] = cb;
    took[0] = 0; took[1] = 0;
    winner = 0;
    if (m_phase == 0) begin
      if (coin_value(ca) > 0 && coin_value(cb) > 0) winner = m_next_slot;
      else if (coin_value(ca) > 0)                  winner = 1;
      else if (coin_value(cb) > 0)                  winner = 2;
      if (winner != 0) begin
        took[winner-1] = 1;
        m_owner     = winner;
        m_credit    = coin_value(code[winner-1]);
        m_next_slot = 3 - winner;
        m_quiet     = 0;
        m_phase     = (m_credit >= PRICE) ? 2 : 1;
      end
    end else if (m_phase == 1) begin
      if (coin_value(code[m_owner-1]) > 0) begin
        took[m_owner-1] = 1;
        m_credit += coin_value(code[m_owner-1]);
        m_quiet  = 0;
        if (m_credit >= PRICE) m_phase = 2;
      end else begin
        m_quiet++;
        if (m_quiet == TIMEOUT) m_phase = 4;
      end
    end else if (m_phase == 2) begin
      if (ack != 0) begin
        m_phase = 3;
        m_sales = (m_sales + 1) % 256;
      end
    end else begin
      m_phase = 0; m_credit = 0; m_owner = 0;
    end
    m_rej_a = (ca != 0) && !took[0];
    m_rej_b = (cb != 0) && !took[1];
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("owner", owner, (m_owner == 1) ? 2'b01 : (m_owner == 2) ? 2'b10 : 2'b00);
      chk("credit", credit, m_credit);
      chk("reject_a", reject_a, m_rej_a);
      chk("reject_b", reject_b, m_rej_b);
      chk("busy", busy, m_phase != 0);
      chk("motor_req", motor_req, m_phase == 2);
      chk("change_vld", change_vld, m_phase == 3);
      chk("refund_vld", refund_vld, m_phase == 4);
      if (m_phase == 3) chk("change", change, m_credit - PRICE);
      if (m_phase == 4) chk("refund", refund, m_credit);
`ifdef VEND_ARBITER_CTRL_AUDIT_EN
      chk("sales_cnt", sales_cnt, m_sales);
`endif
    end
  end

  task automatic cycle(input int ca, input int cb, input int ack);
    coin_a = 2'(ca); coin_b = 2'(cb); motor_ack = 1'(ack);
    @(posedge clk);
    model_step(ca, cb, ack);
    @(negedge clk);
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0);
  endtask

  task automatic do_reset();
    cmp_en = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_motor_req", motor_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    chk("rst_credit", credit, 0);
`ifdef VEND_ARBITER_CTRL_AUDIT_EN
    chk("rst_sales_cnt", sales_cnt, 0);
`endif
    model_reset();
    coin_a = 2'd0; coin_b = 2'd0; motor_ack = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    cmp_en = 1'b1;
  endtask

  initial begin
    rst = 1'b1; coin_a = 2'd0; coin_b = 2'd0; motor_ack = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_owner", owner, 2'b00);
    chk("reset_credit", credit, 0);
    chk("reset_busy", busy, 0);
    chk("reset_motor", motor_req, 0);
    rst = 1'b0;
    cmp_en = 1'b1;

    // Three 5rs coins, motor acknowledges after three cycles.
    cycle(1, 0, 0); cycle(1, 0, 0); cycle(1, 0, 0);
    chk("d1_motor_req", motor_req, 1);
    quiet(3);
    chk("d1_motor_hold", motor_req, 1);
    cycle(0, 0, 1);
    chk("d1_change_vld", change_vld, 1);
    chk("d1_change", change, 0);
    cycle(0, 0, 0);
    chk("d1_credit_clear", credit, 0);

    // Two 10rs coins overshoot by one unit.
    cycle(2, 0, 0); cycle(2, 0, 0);
    chk("d2_credit", credit, 4);
    cycle(0, 0, 1);
    chk("d2_change", change, 1);
    cycle(0, 0, 0);

    // Simultaneous first coins alternate between slots.
    do_reset();
    cycle(1, 1, 0);
    chk("d3_owner_a", owner, 2'b01);
    chk("d3_reject_b", reject_b, 1);
    cycle(1, 0, 0); cycle(1, 0, 0); cycle(0, 0, 1); cycle(0, 0, 0);
    cycle(1, 1, 0);
    chk("d3_owner_b", owner, 2'b10);
    chk("d3_reject_a", reject_a, 1);
    cycle(0, 2, 0); cycle(0, 0, 1); cycle(0, 0, 0);

    // Timeout refund.
    cycle(1, 0, 0);
    quiet(TIMEOUT - 1);
    chk("d4_still_collect", busy && !refund_vld, 1);
    quiet(1);
    chk("d4_refund_vld", refund_vld, 1);
    chk("d4_refund", refund, 1);
    cycle(0, 0, 0);
    chk("d4_owner_none", owner, 2'b00);

    // Coin on the expiry cycle wins over the refund.
    cycle(1, 0, 0);
    quiet(TIMEOUT - 1);
    cycle(1, 0, 0);
    chk("d5_late_coin_credit", credit, 2);
    chk("d5_no_refund", refund_vld, 0);
    quiet(TIMEOUT);
    chk("d5_refund", refund, 2);
    cycle(0, 0, 0);

    // Foreign and invalid coins during a session.
    cycle(1, 0, 0);
    cycle(0, 1, 0);
    chk("d6_reject_b", reject_b, 1);
    chk("d6_credit_b", credit, 1);
    cycle(3, 0, 0);
    chk("d6_reject_a", reject_a, 1);
    chk("d6_credit_a", credit, 1);
    cycle(2, 0, 0); cycle(0, 0, 1); cycle(0, 0, 0);

    // Reset while dispensing.
    cycle(1, 0, 0); cycle(2, 0, 0);
    chk("d7_in_vend", motor_req, 1);
    do_reset();

    for (int i = 0; i < 4000; i++) begin
      int ca, cb, ack;
      ca  = ($urandom_range(0, 99) < 12) ? int'($urandom_range(1, 3)) : 0;
      cb  = ($urandom_range(0, 99) < 12) ? int'($urandom_range(1, 3)) : 0;
      ack = ($urandom_range(0, 99) < 30) ? 1 : 0;
      if ($urandom_range(0, 999) == 0) do_reset();
      else cycle(ca, cb, ack);
    end

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
